// File: rtl/avmm_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | avmm_mem_arbiter_if: two AVMM host ports plus one memory port      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface avmm_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] h0_address;
  logic              h0_read;
  logic              h0_write;
  logic [DATA_W-1:0] h0_writedata;
  logic              h0_waitrequest;
  logic [DATA_W-1:0] h0_readdata;
  logic              h0_readdatavalid;

  logic [ADDR_W-1:0] h1_address;
  logic              h1_read;
  logic              h1_write;
  logic [DATA_W-1:0] h1_writedata;
  logic              h1_waitrequest;
  logic [DATA_W-1:0] h1_readdata;
  logic              h1_readdatavalid;

  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;

  // Arbiter side: takes host commands and memory read data.
  modport slave (
    input  h0_address, h0_read, h0_write, h0_writedata,
    output h0_waitrequest, h0_readdata, h0_readdatavalid,
    input  h1_address, h1_read, h1_write, h1_writedata,
    output h1_waitrequest, h1_readdata, h1_readdatavalid,
    output m_address, m_read, m_write, m_writedata,
    input  m_readdata
  );

  // Environment side: the two hosts and the memory.
  modport master (
    output h0_address, h0_read, h0_write, h0_writedata,
    input  h0_waitrequest, h0_readdata, h0_readdatavalid,
    output h1_address, h1_read, h1_write, h1_writedata,
    input  h1_waitrequest, h1_readdata, h1_readdatavalid,
    input  m_address, m_read, m_write, m_writedata,
    output m_readdata
  );
endinterface
`default_nettype wire

// File: rtl/avmm_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | avmm_mem_arbiter: round-robin arbiter, two AVMM hosts to one memory |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module avmm_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIRST_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  avmm_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic RESET_PTR = (FIRST_PRIO != 0);

  state_t            state;
  logic              rr_ptr;   // 1 = host 1 favoured on a tie
  logic              winner;   // host owning the transaction in flight

  logic              req0;
  logic              req1;
  logic              grant1;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_read;
  logic              sel_write;

  always_comb begin
    req0          = bus.h0_read | bus.h0_write;
    req1          = bus.h1_read | bus.h1_write;
    grant1        = req1 & (~req0 | rr_ptr);
    sel_address   = grant1 ? bus.h1_address   : bus.h0_address;
    sel_writedata = grant1 ? bus.h1_writedata : bus.h0_writedata;
    sel_write     = grant1 ? bus.h1_write     : bus.h0_write;
    sel_read      = grant1 ? bus.h1_read      : bus.h0_read;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      rr_ptr               <= RESET_PTR;
      winner               <= 1'b0;
      bus.h0_waitrequest   <= 1'b1;
      bus.h1_waitrequest   <= 1'b1;
      bus.h0_readdatavalid <= 1'b0;
      bus.h1_readdatavalid <= 1'b0;
      bus.h0_readdata      <= '0;
      bus.h1_readdata      <= '0;
      bus.m_read           <= 1'b0;
      bus.m_write          <= 1'b0;
      bus.m_address        <= '0;
      bus.m_writedata      <= '0;
    end else begin
      bus.h0_readdatavalid <= 1'b0;
      bus.h1_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            winner             <= grant1;
            rr_ptr             <= ~grant1;
            bus.m_address      <= sel_address;
            bus.m_writedata    <= sel_writedata;
            // A write with read also asserted is issued as a write only.
            bus.m_write        <= sel_write;
            bus.m_read         <= sel_read & ~sel_write;
            bus.h0_waitrequest <= grant1;
            bus.h1_waitrequest <= ~grant1;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          bus.h0_waitrequest <= 1'b1;
          bus.h1_waitrequest <= 1'b1;
          bus.m_read         <= 1'b0;
          bus.m_write        <= 1'b0;
          state              <= bus.m_write ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (winner) begin
            bus.h1_readdata      <= bus.m_readdata;
            bus.h1_readdatavalid <= 1'b1;
          end else begin
            bus.h0_readdata      <= bus.m_readdata;
            bus.h0_readdatavalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avmm_mem_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_avmm_mem_arbiter: scoreboard bench with a 256x8 memory model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_avmm_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avmm_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  avmm_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIRST_PRIO(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory: 1-cycle registered read; 200..255 writable only after key 79/23 at 126/127.
  logic [7:0] mem [0:255] = '{default: 8'h00};
  logic       unlocked;
  assign unlocked = (mem[126] == 8'd79) && (mem[127] == 8'd23);

  always @(posedge clk) begin
    if (bus.m_write && !((bus.m_address >= 8'd200) && !unlocked))
      mem[bus.m_address] <= bus.m_writedata[7:0];
    if (bus.m_read)
      bus.m_readdata <= {24'h0, mem[bus.m_address]};
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdv_cnt[2] = '{0, 0};
  int          acc_cyc[2] = '{0, 0};
  int          grants[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  task automatic drive(input int h, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [31:0] d);
    if (h == 0) begin
      bus.h0_address = a; bus.h0_writedata = d; bus.h0_read = rd; bus.h0_write = wr;
    end else begin
      bus.h1_address = a; bus.h1_writedata = d; bus.h1_read = rd; bus.h1_write = wr;
    end
  endtask

  task automatic release_host(input int h);
    if (h == 0) begin bus.h0_read = 1'b0; bus.h0_write = 1'b0; end
    else        begin bus.h1_read = 1'b0; bus.h1_write = 1'b0; end
  endtask

  function automatic logic wreq(input int h);
    return (h == 0) ? bus.h0_waitrequest : bus.h1_waitrequest;
  endfunction

  // Issue one command from #1 after a posedge; returns at #1 after the posedge ending acceptance.
  task automatic do_cmd(input int h, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input bit exp_valid, input logic [31:0] exp);
    bit acc = 1'b0;
    if (rd && !wr && exp_valid) begin
      if (h == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
    end
    drive(h, rd, wr, a, d);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (wreq(h) === 1'b0) acc = 1'b1;
      else @(posedge clk);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout host=%0d addr=%0d waitrequest=%b required 0 within 20 cycles", h, a, wreq(h));
    end else begin
      grants.push_back(h);
      acc_cyc[h] = cyc;
    end
    @(posedge clk);
    #1 release_host(h);
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.h0_readdatavalid === 1'b1) begin
        rdv_cnt[0]++; checks++;
        if (exp_q0.size() == 0) begin
          errors++; $display("FAIL h0_unexpected_rdv readdata=%h required no pulse", bus.h0_readdata);
        end else begin
          e = exp_q0.pop_front();
          if (bus.h0_readdata !== e) begin
            errors++; $display("FAIL h0_readdata got=%h required=%h", bus.h0_readdata, e);
          end
        end
      end
      if (bus.h1_readdatavalid === 1'b1) begin
        rdv_cnt[1]++; checks++;
        if (exp_q1.size() == 0) begin
          errors++; $display("FAIL h1_unexpected_rdv readdata=%h required no pulse", bus.h1_readdata);
        end else begin
          e = exp_q1.pop_front();
          if (bus.h1_readdata !== e) begin
            errors++; $display("FAIL h1_readdata got=%h required=%h", bus.h1_readdata, e);
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending h0=%0d h1=%0d required 0", exp_q0.size(), exp_q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    release_host(0); release_host(1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    release_host(0); release_host(1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.h0_waitrequest, bus.h1_waitrequest} !== 2'b11) begin
      errors++; $display("FAIL reset_waitrequest got=%b required=11", {bus.h0_waitrequest, bus.h1_waitrequest});
    end
    checks++;
    if ({bus.h0_readdatavalid, bus.h1_readdatavalid, bus.m_read, bus.m_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b required=0000",
                         {bus.h0_readdatavalid, bus.h1_readdatavalid, bus.m_read, bus.m_write});
    end
    checks++;
    if (bus.h0_readdata !== 32'h0 || bus.h1_readdata !== 32'h0) begin
      errors++; $display("FAIL reset_readdata got=%h/%h required=0/0", bus.h0_readdata, bus.h1_readdata);
    end
    checks++;
    if (bus.m_address !== 8'h0 || bus.m_writedata !== 32'h0) begin
      errors++; $display("FAIL reset_mbus got=%h/%h required=0/0", bus.m_address, bus.m_writedata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    // Write: request seen in cycle 0, accepted in cycle 1.
    drive(0, 1'b0, 1'b1, 8'd5, 32'hA5);
    @(negedge clk);
    checks++;
    if (bus.h0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL single_wr_c0_wait got=%b required=1", bus.h0_waitrequest);
    end
    @(negedge clk);
    checks++;
    if ({bus.h0_waitrequest, bus.h1_waitrequest, bus.m_write, bus.m_read} !== 4'b0110 ||
        bus.m_address !== 8'd5 || bus.m_writedata !== 32'hA5) begin
      errors++; $display("FAIL single_wr_c1 wait0/wait1/mw/mr=%b addr=%h data=%h required 0110/05/a5",
                         {bus.h0_waitrequest, bus.h1_waitrequest, bus.m_write, bus.m_read},
                         bus.m_address, bus.m_writedata);
    end
    @(posedge clk); #1 release_host(0);
    @(negedge clk);
    checks++;
    if (bus.h0_waitrequest !== 1'b1 || bus.m_write !== 1'b0) begin
      errors++; $display("FAIL single_wr_c2 wait=%b mw=%b required 1/0", bus.h0_waitrequest, bus.m_write);
    end
    // Read back: readdatavalid in cycle 3.
    @(posedge clk); #1;
    exp_q0.push_back(32'hA5);
    drive(0, 1'b1, 1'b0, 8'd5, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.h0_waitrequest !== 1'b0 || bus.m_read !== 1'b1) begin
      errors++; $display("FAIL single_rd_c1 wait=%b mr=%b required 0/1", bus.h0_waitrequest, bus.m_read);
    end
    @(posedge clk); #1 release_host(0);
    @(negedge clk);
    checks++;
    if (bus.h0_readdatavalid !== 1'b0 || bus.h0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL single_rd_c2 rdv=%b wait=%b required 0/1", bus.h0_readdatavalid, bus.h0_waitrequest);
    end
    @(negedge clk);
    checks++;
    if (bus.h0_readdatavalid !== 1'b1 || bus.h0_readdata !== 32'hA5 ||
        bus.h1_readdatavalid !== 1'b0 || bus.h1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL single_rd_c3 rdv=%b data=%h h1rdv=%b h1wait=%b required 1/a5/0/1",
                         bus.h0_readdatavalid, bus.h0_readdata, bus.h1_readdatavalid, bus.h1_waitrequest);
    end
    @(negedge clk);
    checks++;
    if (bus.h0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL single_rd_pulse_width rdv=%b required 0", bus.h0_readdatavalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    do_reset();
    fork
      do_cmd(0, 1'b0, 1'b1, 8'd10, 32'h11, 1'b0, 32'h0);
      do_cmd(1, 1'b0, 1'b1, 8'd10, 32'h22, 1'b0, 32'h0);
    join
    checks++;
    if (!(acc_cyc[0] < acc_cyc[1])) begin
      errors++; $display("FAIL simul_order h0_cyc=%0d h1_cyc=%0d required h0 first", acc_cyc[0], acc_cyc[1]);
    end
    do_cmd(0, 1'b1, 1'b0, 8'd10, 32'h0, 1'b1, 32'h22);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int c0 = rdv_cnt[0];
    int c1 = rdv_cnt[1];
    int bad = 0;
    grants.delete();
    fork
      for (int i = 0; i < 8; i++) do_cmd(0, 1'b1, 1'b0, 8'd10, 32'h0, 1'b1, 32'h22);
      for (int j = 0; j < 8; j++) do_cmd(1, 1'b1, 1'b0, 8'd5, 32'h0, 1'b1, 32'hA5);
    join
    wait_drain();
    for (int k = 1; k < grants.size(); k++) if (grants[k] == grants[k-1]) bad++;
    checks++;
    if (grants.size() != 16 || bad != 0) begin
      errors++; $display("FAIL b2b_alternation grants=%0d repeats=%0d required 16/0", grants.size(), bad);
    end
    checks++;
    if (rdv_cnt[0] - c0 != 8 || rdv_cnt[1] - c1 != 8) begin
      errors++; $display("FAIL b2b_rdv_count h0=%0d h1=%0d required 8/8", rdv_cnt[0] - c0, rdv_cnt[1] - c1);
    end
  endtask

  task automatic test_page2();
    do_cmd(1, 1'b0, 1'b1, 8'd200, 32'h5A, 1'b0, 32'h0);
    do_cmd(1, 1'b1, 1'b0, 8'd200, 32'h0, 1'b1, 32'h00);
    wait_drain();
    do_cmd(0, 1'b0, 1'b1, 8'd126, 32'd79, 1'b0, 32'h0);
    do_cmd(0, 1'b0, 1'b1, 8'd127, 32'd23, 1'b0, 32'h0);
    do_cmd(1, 1'b0, 1'b1, 8'd200, 32'h5A, 1'b0, 32'h0);
    do_cmd(1, 1'b1, 1'b0, 8'd200, 32'h0, 1'b1, 32'h5A);
    wait_drain();
  endtask

  task automatic test_rdwr_both();
    int c0 = rdv_cnt[0];
    do_cmd(0, 1'b1, 1'b1, 8'd3, 32'h77, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    checks++;
    if (rdv_cnt[0] != c0) begin
      errors++; $display("FAIL rdwr_no_rdv pulses=%0d required 0", rdv_cnt[0] - c0);
    end
    @(posedge clk); #1;
    do_cmd(0, 1'b1, 1'b0, 8'd3, 32'h0, 1'b1, 32'h77);
    wait_drain();
  endtask

  task automatic test_reset_mid_read();
    // An h0 read leaves the pointer on h1, so FIRST_PRIO after reset is observable.
    drive(0, 1'b1, 1'b0, 8'd7, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.h0_waitrequest !== 1'b0) begin
      errors++; $display("FAIL midrd_accept wait=%b required 0", bus.h0_waitrequest);
    end
    @(posedge clk);
    #1 release_host(0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.h0_readdatavalid !== 1'b0 || bus.h0_waitrequest !== 1'b1 || bus.m_read !== 1'b0 ||
        bus.h0_readdata !== 32'h0) begin
      errors++; $display("FAIL midrd_reset rdv=%b wait=%b mr=%b data=%h required 0/1/0/0",
                         bus.h0_readdatavalid, bus.h0_waitrequest, bus.m_read, bus.h0_readdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      do_cmd(0, 1'b0, 1'b1, 8'd20, 32'h01, 1'b0, 32'h0);
      do_cmd(1, 1'b0, 1'b1, 8'd20, 32'h02, 1'b0, 32'h0);
    join
    checks++;
    if (!(acc_cyc[0] < acc_cyc[1])) begin
      errors++; $display("FAIL midrd_first_prio h0_cyc=%0d h1_cyc=%0d required h0 first", acc_cyc[0], acc_cyc[1]);
    end
    do_cmd(1, 1'b1, 1'b0, 8'd20, 32'h0, 1'b1, 32'h02);
    wait_drain();
  endtask

  initial begin
    release_host(0); release_host(1);
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 32'h0);
    fork
      forever @(posedge clk) cyc++;
      monitor();
    join_none
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_page2();
    test_rdwr_both();
    test_reset_mid_read();
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
